// File: rtl/lookup_cfg_pkg.sv
// Shared constants, header layout and FSM encoding for the lookup-stage
// configuration writer.
package lookup_cfg_pkg;

  localparam logic [7:0] OP_CAM_WR = 8'h01;
  localparam logic [7:0] OP_ACT_WR = 8'h02;

  // Beat counts include the header beat.
  localparam int CAM_BEATS = 9;
  localparam int ACT_BEATS = 4;
  localparam int KEY_BEATS = (CAM_BEATS - 1) / 2;

  localparam int HDR_OP_LSB    = 248;
  localparam int HDR_OP_W      = 8;
  localparam int HDR_ADDR_LSB  = 244;
  localparam int HDR_ADDR_W    = 4;
  localparam int HDR_STAGE_LSB = 240;
  localparam int HDR_STAGE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY    = 3'd1,
    ST_MASK   = 3'd2,
    ST_ACT    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_DROP   = 3'd5
  } cfg_state_e;

  typedef struct packed {
    logic [HDR_OP_W-1:0]    op;
    logic [HDR_ADDR_W-1:0]  addr;
    logic [HDR_STAGE_W-1:0] stage;
  } cfg_hdr_t;

  function automatic cfg_hdr_t hdr_decode(input logic [255:0] word);
    cfg_hdr_t h;
    h.op    = word[HDR_OP_LSB    +: HDR_OP_W];
    h.addr  = word[HDR_ADDR_LSB  +: HDR_ADDR_W];
    h.stage = word[HDR_STAGE_LSB +: HDR_STAGE_W];
    return h;
  endfunction

endpackage

// File: rtl/lookup_cfg_writer.sv
// Assembles CAM key/mask and action entries from 256-bit control beats and
// issues single-cycle write strobes into the stage's lookup engine.
//
// state  | meaning
// IDLE   | waiting for a header beat
// KEY    | collecting key beats (message beats 1..4)
// MASK   | collecting mask beats (message beats 5..8)
// ACT    | collecting action beats (message beats 1..3)
// COMMIT | one-cycle write strobe, ctrl_ready low
// DROP   | discarding beats until ctrl_last
module lookup_cfg_writer
  import lookup_cfg_pkg::*;
#(
  parameter int STAGE   = 0,
  parameter int ACT_LEN = 25,
  parameter int ENTRY_W = 1024,
  parameter int DATA_W  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     ctrl_data,
  input  logic                  ctrl_valid,
  input  logic                  ctrl_last,
  output logic                  ctrl_ready,
  output logic [ENTRY_W-1:0]    lookup_din,
  output logic [ENTRY_W-1:0]    lookup_din_mask,
  output logic [3:0]            lookup_din_addr,
  output logic                  lookup_din_en,
  output logic [ACT_LEN*25-1:0] action_data_in,
  output logic [3:0]            action_addr,
  output logic                  action_en,
  output logic [15:0]           cfg_err_cnt
);

  localparam int ACT_W = ACT_LEN * 25;
  localparam logic [3:0] KEY_END = 4'(KEY_BEATS);
  localparam logic [3:0] CAM_END = 4'(CAM_BEATS - 1);
  localparam logic [3:0] ACT_END = 4'(ACT_BEATS - 1);

  cfg_state_e state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic       commit_cam_q, commit_cam_d;

  logic       accept;
  cfg_hdr_t   hdr;
  logic       stage_hit;
  logic       op_cam, op_act;

  logic       hdr_take;
  logic       ld_key, ld_mask, ld_act;
  logic       pub_cam, pub_act;
  logic       err_inc;

  logic [1:0] key_idx, mask_idx, act_idx;

  logic [ENTRY_W-1:0] key_buf, key_nxt;
  logic [ENTRY_W-1:0] mask_buf, mask_nxt;
  logic [ACT_W-1:0]   act_buf, act_nxt;
  logic [3:0]         addr_buf;

  assign accept    = ctrl_valid && ctrl_ready;
  assign hdr       = hdr_decode(ctrl_data);
  assign stage_hit = (hdr.stage == 4'(STAGE));
  assign op_cam    = (hdr.op == OP_CAM_WR);
  assign op_act    = (hdr.op == OP_ACT_WR);

  // Beat counter holds the message position of the beat being presented.
  assign key_idx  = 2'(beat_q - 4'd1);
  assign mask_idx = 2'(beat_q - KEY_END - 4'd1);
  assign act_idx  = 2'(beat_q - 4'd1);

  assign lookup_din_en = (state_q == ST_COMMIT) &&  commit_cam_q;
  assign action_en     = (state_q == ST_COMMIT) && !commit_cam_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      commit_cam_q <= 1'b0;
      ctrl_ready   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      commit_cam_q <= commit_cam_d;
      ctrl_ready   <= (state_d != ST_COMMIT);
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    commit_cam_d = commit_cam_q;
    hdr_take     = 1'b0;
    ld_key       = 1'b0;
    ld_mask      = 1'b0;
    ld_act       = 1'b0;
    pub_cam      = 1'b0;
    pub_act      = 1'b0;
    err_inc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hdr_take = 1'b1;
          beat_d   = 4'd1;
          if (!stage_hit) begin
            state_d = ctrl_last ? ST_IDLE : ST_DROP;
          end else if (!(op_cam || op_act)) begin
            err_inc = 1'b1;
            state_d = ctrl_last ? ST_IDLE : ST_DROP;
          end else if (ctrl_last) begin
            err_inc = 1'b1;
          end else begin
            state_d = op_cam ? ST_KEY : ST_ACT;
          end
        end
      end

      ST_KEY: begin
        if (accept) begin
          ld_key = 1'b1;
          beat_d = beat_q + 4'd1;
          if (ctrl_last) begin
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end else if (beat_q == KEY_END) begin
            state_d = ST_MASK;
          end
        end
      end

      ST_MASK: begin
        if (accept) begin
          ld_mask = 1'b1;
          beat_d  = beat_q + 4'd1;
          if (beat_q == CAM_END) begin
            if (ctrl_last) begin
              pub_cam      = 1'b1;
              commit_cam_d = 1'b1;
              state_d      = ST_COMMIT;
            end else begin
              err_inc = 1'b1;
              state_d = ST_DROP;
            end
          end else if (ctrl_last) begin
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_ACT: begin
        if (accept) begin
          ld_act = 1'b1;
          beat_d = beat_q + 4'd1;
          if (beat_q == ACT_END) begin
            if (ctrl_last) begin
              pub_act      = 1'b1;
              commit_cam_d = 1'b0;
              state_d      = ST_COMMIT;
            end else begin
              err_inc = 1'b1;
              state_d = ST_DROP;
            end
          end else if (ctrl_last) begin
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_COMMIT: state_d = ST_IDLE;

      ST_DROP: begin
        if (accept && ctrl_last) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    key_nxt = key_buf;
    key_nxt[int'(key_idx)*DATA_W +: DATA_W] = ctrl_data;
  end

  always_comb begin
    mask_nxt = mask_buf;
    mask_nxt[int'(mask_idx)*DATA_W +: DATA_W] = ctrl_data;
  end

  // The last action beat only partially fills the entry; its upper bits drop.
  always_comb begin
    act_nxt = act_buf;
    if (act_idx < 2'd2) begin
      act_nxt[int'(act_idx)*DATA_W +: DATA_W] = ctrl_data;
    end else begin
      act_nxt[ACT_W-1:2*DATA_W] = ctrl_data[ACT_W-2*DATA_W-1:0];
    end
  end

  // Outputs are published only at commit so aborted messages never disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_buf         <= '0;
      mask_buf        <= '0;
      act_buf         <= '0;
      addr_buf        <= '0;
      lookup_din      <= '0;
      lookup_din_mask <= '0;
      lookup_din_addr <= '0;
      action_data_in  <= '0;
      action_addr     <= '0;
      cfg_err_cnt     <= '0;
    end else begin
      if (hdr_take) addr_buf <= hdr.addr;
      if (ld_key)   key_buf  <= key_nxt;
      if (ld_mask)  mask_buf <= mask_nxt;
      if (ld_act)   act_buf  <= act_nxt;
      if (pub_cam) begin
        lookup_din      <= key_buf;
        lookup_din_mask <= mask_nxt;
        lookup_din_addr <= addr_buf;
      end
      if (pub_act) begin
        action_data_in <= act_nxt;
        action_addr    <= addr_buf;
      end
      if (err_inc && (cfg_err_cnt != 16'hFFFF)) cfg_err_cnt <= cfg_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Scoreboarded bench for lookup_cfg_writer: expected commits are queued as
// messages are sent and checked when a write strobe appears.
module tb_lookup_cfg_writer;

  localparam int ACT_W = 625;

  logic              clk = 1'b0;
  logic              rst;
  logic [255:0]      ctrl_data;
  logic              ctrl_valid;
  logic              ctrl_last;
  logic              ctrl_ready;
  logic [1023:0]     lookup_din;
  logic [1023:0]     lookup_din_mask;
  logic [3:0]        lookup_din_addr;
  logic              lookup_din_en;
  logic [ACT_W-1:0]  action_data_in;
  logic [3:0]        action_addr;
  logic              action_en;
  logic [15:0]       cfg_err_cnt;

  typedef struct {
    logic             is_cam;
    logic [3:0]       addr;
    logic [1023:0]    key;
    logic [1023:0]    mask;
    logic [ACT_W-1:0] act;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  lookup_cfg_writer #(
    .STAGE(0), .ACT_LEN(25), .ENTRY_W(1024), .DATA_W(256)
  ) dut (
    .clk(clk), .rst(rst),
    .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .ctrl_last(ctrl_last),
    .ctrl_ready(ctrl_ready),
    .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
    .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
    .action_data_in(action_data_in), .action_addr(action_addr),
    .action_en(action_en), .cfg_err_cnt(cfg_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Commit monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (lookup_din_en === 1'b1 || action_en === 1'b1) begin
      tests_run++;
      if (lookup_din_en === 1'b1 && action_en === 1'b1) begin
        tests_failed++;
        $display("FAIL strobe_overlap lookup_din_en=%0b action_en=%0b required not both", lookup_din_en, action_en);
      end
      tests_run++;
      if (ctrl_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL commit_ready actual=%0b required=0", ctrl_ready);
      end
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe cam=%0b act=%0b required no strobe", lookup_din_en, action_en);
      end else begin
        mon_e = sb.pop_front();
        if (lookup_din_en !== mon_e.is_cam) begin
          tests_failed++;
          $display("FAIL strobe_kind cam_en=%0b required cam_en=%0b", lookup_din_en, mon_e.is_cam);
        end else if (mon_e.is_cam) begin
          tests_run++;
          if (lookup_din_addr !== mon_e.addr) begin
            tests_failed++;
            $display("FAIL cam_addr actual=%h required=%h", lookup_din_addr, mon_e.addr);
          end
          for (int w = 0; w < 4; w++) begin
            tests_run++;
            if (lookup_din[w*256 +: 256] !== mon_e.key[w*256 +: 256]) begin
              tests_failed++;
              $display("FAIL cam_key word%0d actual=%h required=%h", w, lookup_din[w*256 +: 256], mon_e.key[w*256 +: 256]);
            end
            tests_run++;
            if (lookup_din_mask[w*256 +: 256] !== mon_e.mask[w*256 +: 256]) begin
              tests_failed++;
              $display("FAIL cam_mask word%0d actual=%h required=%h", w, lookup_din_mask[w*256 +: 256], mon_e.mask[w*256 +: 256]);
            end
          end
        end else begin
          tests_run++;
          if (action_addr !== mon_e.addr) begin
            tests_failed++;
            $display("FAIL act_addr actual=%h required=%h", action_addr, mon_e.addr);
          end
          tests_run++;
          if (action_data_in !== mon_e.act) begin
            tests_failed++;
            $display("FAIL act_data actual=%h required=%h", action_data_in, mon_e.act);
          end
        end
      end
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Header with random filler in the ignored bits.
  function automatic logic [255:0] hdr(input logic [7:0] op, input logic [3:0] a, input logic [3:0] s);
    logic [255:0] r;
    r = rand256();
    r[255:240] = {op, a, s};
    return r;
  endfunction

  // Returns one time unit after the accepting edge with valid already dropped.
  task automatic send_beat(input logic [255:0] d, input logic last, input int gap, output time t_acc);
    int n;
    @(negedge clk);
    ctrl_valid = 1'b0;
    repeat (gap) @(negedge clk);
    ctrl_data  = d;
    ctrl_last  = last;
    ctrl_valid = 1'b1;
    n = 0;
    while (ctrl_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ctrl_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_timeout ctrl_ready=%0b required=1 within 20 cycles", ctrl_ready);
    end
    @(posedge clk);
    t_acc = $time;
    #1 ctrl_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [255:0] beats[$], input int last_idx, input int max_gap,
                          output time t_first, output time t_last);
    time t;
    int  g;
    t_first = 0;
    t_last  = 0;
    for (int i = 0; i < beats.size(); i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      send_beat(beats[i], (i == last_idx), g, t);
      if (i == 0) t_first = t;
      t_last = t;
    end
  endtask

  task automatic settle_and_check(input string name, input logic [15:0] exp_err);
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_pending actual=%0d commits outstanding required=0", name, sb.size());
    end
    tests_run++;
    if (cfg_err_cnt !== exp_err) begin
      tests_failed++;
      $display("FAIL %s_err_cnt actual=%0d required=%0d", name, cfg_err_cnt, exp_err);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ctrl_valid = 1'b0;
    ctrl_last  = 1'b0;
    ctrl_data  = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ctrl_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready actual=%0b required=0", ctrl_ready);
    end
    tests_run++;
    if ({lookup_din_en, action_en, lookup_din_addr, action_addr, cfg_err_cnt} !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_ctl actual=%0b%0b %h %h %h required all zero", lookup_din_en, action_en, lookup_din_addr, action_addr, cfg_err_cnt);
    end
    tests_run++;
    if (lookup_din !== '0 || lookup_din_mask !== '0 || action_data_in !== '0) begin
      tests_failed++;
      $display("FAIL reset_data actual nonzero required all zero");
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (ctrl_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_ready actual=%0b required=1", ctrl_ready);
    end
  endtask

  task automatic test_cam_write();
    logic [255:0] m[$];
    exp_t e;
    time t0, t1;
    e.is_cam = 1'b1;
    e.addr   = 4'h5;
    e.act    = '0;
    m.push_back(hdr(8'h01, 4'h5, 4'h0));
    for (int k = 0; k < 4; k++) begin
      m.push_back(256'hA0 + 256'(k));
      e.key[k*256 +: 256] = 256'hA0 + 256'(k);
    end
    for (int k = 0; k < 4; k++) begin
      m.push_back(256'hB0 + 256'(k));
      e.mask[k*256 +: 256] = 256'hB0 + 256'(k);
    end
    sb.push_back(e);
    send_msg(m, 8, 0, t0, t1);
    tests_run++;
    if (lookup_din_en !== 1'b1 || ctrl_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL cam_strobe_latency en=%0b ready=%0b required en=1 ready=0", lookup_din_en, ctrl_ready);
    end
    tests_run++;
    if (lookup_din_addr !== 4'h5 || lookup_din[255:0] !== 256'hA0 || lookup_din_mask[1023:768] !== 256'hB3) begin
      tests_failed++;
      $display("FAIL cam_fields addr=%h key0=%h mask3=%h required 5 a0 b3", lookup_din_addr, lookup_din[255:0], lookup_din_mask[1023:768]);
    end
    tests_run++;
    if (t1 - t0 != 80) begin
      tests_failed++;
      $display("FAIL cam_beat_rate actual=%0t required=80", t1 - t0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (lookup_din_en !== 1'b0 || ctrl_ready !== 1'b1 || lookup_din_addr !== 4'h5) begin
      tests_failed++;
      $display("FAIL cam_one_cycle en=%0b ready=%0b addr=%h required 0 1 5", lookup_din_en, ctrl_ready, lookup_din_addr);
    end
    settle_and_check("cam_write", 16'd0);
  endtask

  task automatic test_action_write();
    logic [255:0] m[$];
    exp_t e;
    time t0, t1;
    e.is_cam = 1'b0;
    e.addr   = 4'hF;
    e.key    = '0;
    e.mask   = '0;
    e.act    = '1;
    m.push_back(hdr(8'h02, 4'hF, 4'h0));
    for (int k = 0; k < 3; k++) m.push_back('1);
    sb.push_back(e);
    send_msg(m, 3, 0, t0, t1);
    tests_run++;
    if (action_en !== 1'b1 || lookup_din_en !== 1'b0 || action_addr !== 4'hF) begin
      tests_failed++;
      $display("FAIL act_strobe act_en=%0b cam_en=%0b addr=%h required 1 0 f", action_en, lookup_din_en, action_addr);
    end
    tests_run++;
    if (t1 - t0 != 30) begin
      tests_failed++;
      $display("FAIL act_beat_rate actual=%0t required=30", t1 - t0);
    end
    settle_and_check("action_write", 16'd0);
  endtask

  task automatic test_back_to_back();
    logic [255:0] mc[$], ma[$];
    logic [255:0] d;
    exp_t ec, ea;
    time c0, c1, a0, a1;
    ec.is_cam = 1'b1; ec.addr = 4'h3; ec.act = '0;
    ea.is_cam = 1'b0; ea.addr = 4'h9; ea.key = '0; ea.mask = '0;
    mc.push_back(hdr(8'h01, 4'h3, 4'h0));
    for (int k = 0; k < 4; k++) begin
      d = rand256(); mc.push_back(d); ec.key[k*256 +: 256] = d;
    end
    for (int k = 0; k < 4; k++) begin
      d = rand256(); mc.push_back(d); ec.mask[k*256 +: 256] = d;
    end
    ma.push_back(hdr(8'h02, 4'h9, 4'h0));
    d = rand256(); ma.push_back(d); ea.act[255:0]   = d;
    d = rand256(); ma.push_back(d); ea.act[511:256] = d;
    d = rand256(); ma.push_back(d); ea.act[624:512] = d[112:0];
    sb.push_back(ec);
    sb.push_back(ea);
    send_msg(mc, 8, 0, c0, c1);
    send_msg(ma, 3, 0, a0, a1);
    tests_run++;
    if (a0 - c0 != 100 || a1 - c0 != 130) begin
      tests_failed++;
      $display("FAIL b2b_throughput act_hdr=%0t act_last=%0t required 100 130", a0 - c0, a1 - c0);
    end
    tests_run++;
    if (lookup_din_addr !== 4'h3 || action_addr !== 4'h9) begin
      tests_failed++;
      $display("FAIL b2b_addr_hold cam=%h act=%h required 3 9", lookup_din_addr, action_addr);
    end
    settle_and_check("back_to_back", 16'd0);
  endtask

  task automatic test_stage_mismatch();
    logic [255:0] m[$];
    time t0, t1;
    m.push_back(hdr(8'h01, 4'h2, 4'h3));
    for (int k = 0; k < 8; k++) m.push_back(rand256());
    send_msg(m, 8, 0, t0, t1);
    settle_and_check("stage_mismatch", 16'd0);
    tests_run++;
    if (lookup_din_addr !== 4'h3) begin
      tests_failed++;
      $display("FAIL mismatch_addr_hold actual=%h required=3", lookup_din_addr);
    end
  endtask

  task automatic test_framing();
    logic [255:0] m[$];
    logic [255:0] d;
    exp_t e;
    time t0, t1;

    m = {};
    m.push_back(hdr(8'h02, 4'h1, 4'h0));
    m.push_back(rand256());
    m.push_back(rand256());
    send_msg(m, 2, 0, t0, t1);
    settle_and_check("early_last", 16'd1);

    m = {};
    m.push_back(hdr(8'h01, 4'h6, 4'h0));
    for (int k = 0; k < 10; k++) m.push_back(rand256());
    send_msg(m, 10, 0, t0, t1);
    settle_and_check("missing_last", 16'd2);

    m = {};
    e.is_cam = 1'b0; e.addr = 4'h7; e.key = '0; e.mask = '0;
    m.push_back(hdr(8'h02, 4'h7, 4'h0));
    d = rand256(); m.push_back(d); e.act[255:0]   = d;
    d = rand256(); m.push_back(d); e.act[511:256] = d;
    d = rand256(); m.push_back(d); e.act[624:512] = d[112:0];
    sb.push_back(e);
    send_msg(m, 3, 0, t0, t1);
    settle_and_check("after_error", 16'd2);

    m = {};
    m.push_back(hdr(8'h01, 4'h4, 4'h0));
    send_msg(m, 0, 0, t0, t1);
    settle_and_check("header_last", 16'd3);

    m = {};
    m.push_back(hdr(8'h33, 4'h4, 4'h0));
    m.push_back(rand256());
    send_msg(m, 1, 0, t0, t1);
    settle_and_check("bad_opcode", 16'd4);

    m = {};
    e.is_cam = 1'b1; e.addr = 4'hC; e.act = '0;
    m.push_back(hdr(8'h01, 4'hC, 4'h0));
    for (int k = 0; k < 4; k++) begin
      d = rand256(); m.push_back(d); e.key[k*256 +: 256] = d;
    end
    for (int k = 0; k < 4; k++) begin
      d = rand256(); m.push_back(d); e.mask[k*256 +: 256] = d;
    end
    sb.push_back(e);
    send_msg(m, 8, 0, t0, t1);
    settle_and_check("recovered_cam", 16'd4);
  endtask

  task automatic test_gap_reset();
    logic [255:0] m[$];
    logic [255:0] d;
    exp_t e;
    time t0, t1;
    m.push_back(hdr(8'h01, 4'hA, 4'h0));
    for (int k = 0; k < 4; k++) m.push_back(rand256());
    send_msg(m, 99, 3, t0, t1);
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (ctrl_ready !== 1'b0 || cfg_err_cnt !== 16'd0 || lookup_din_addr !== 4'h0 || action_addr !== 4'h0) begin
      tests_failed++;
      $display("FAIL midmsg_reset ready=%0b err=%0d cam_addr=%h act_addr=%h required 0 0 0 0", ctrl_ready, cfg_err_cnt, lookup_din_addr, action_addr);
    end
    @(negedge clk);
    rst = 1'b0;

    m = {};
    e.is_cam = 1'b0; e.addr = 4'hD; e.key = '0; e.mask = '0;
    m.push_back(hdr(8'h02, 4'hD, 4'h0));
    d = rand256(); m.push_back(d); e.act[255:0]   = d;
    d = rand256(); m.push_back(d); e.act[511:256] = d;
    d = rand256(); m.push_back(d); e.act[624:512] = d[112:0];
    sb.push_back(e);
    send_msg(m, 3, 3, t0, t1);
    tests_run++;
    if (action_en !== 1'b1 || action_addr !== 4'hD) begin
      tests_failed++;
      $display("FAIL post_reset_act en=%0b addr=%h required 1 d", action_en, action_addr);
    end
    settle_and_check("gap_reset", 16'd0);
  endtask

  initial begin
    test_reset();
    test_cam_write();
    test_action_write();
    test_back_to_back();
    test_stage_mismatch();
    test_framing();
    test_gap_reset();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lookup_cfg_writer.md
# lookup_cfg_writer

Control-plane initiator for one match-action stage. It accepts 256-bit control words over a valid/ready stream and assembles them into complete CAM entries (key + mask) or action-RAM entries. It then issues single-cycle write pulses on the lookup engine's control channel and action-RAM write port. It sits between the control-packet parser and the stage's `lookup_engine`, and it drives every control input that engine exposes.

## Interface
Parameters:
- `STAGE`, 0: stage ID this instance accepts; messages for other stages are discarded.
- `ACT_LEN`, 25: width of one action; the action entry is `ACT_LEN*25` bits (625 by default).
- `ENTRY_W`, 1024: CAM key/mask width.
- `DATA_W`, 256: control word width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ctrl_data`  in  256  control word.
- `ctrl_valid`  in  1  word valid.
- `ctrl_last`  in  1  final word of message.
- `ctrl_ready`  out  1  word accepted when valid && ready.
- `lookup_din`  out  1024  CAM key.
- `lookup_din_mask`  out  1024  CAM mask.
- `lookup_din_addr`  out  4  CAM entry address.
- `lookup_din_en`  out  1  one-cycle CAM write strobe.
- `action_data_in`  out  ACT_LEN*25  action entry.
- `action_addr`  out  4  action RAM address.
- `action_en`  out  1  one-cycle action RAM write strobe.
- `cfg_err_cnt`  out  16  saturating count of malformed messages.

## Operation
- Header word (beat 0) fields:
  - `[255:248]` opcode: 0x01 = CAM write, 0x02 = action write.
  - `[247:244]` address.
  - `[243:240]` stage.
  - Remaining bits are ignored.
- CAM message: 9 beats. The header is followed by 4 key beats, then 4 mask beats.
  - Data beat k (k = 0..3) fills bits `[256k+255:256k]` of the key or mask. The lowest-order word arrives first.
- Action message: 4 beats. The header is followed by 3 data beats.
  - Data beats fill `action_data_in[255:0]`, `[511:256]`, and `[624:512]` in that order.
  - On the third data beat only bits `[112:0]` are used; the rest are ignored.
- States:
  - IDLE: waits for the header. On acceptance:
    - stage match and opcode 0x01 → KEY
    - stage match and opcode 0x02 → ACT
    - stage mismatch → DROP, no error
    - unknown opcode → DROP with error
    - if `ctrl_last` is set on the header of a valid opcode → IDLE with error
  - KEY (4 beats) → MASK (4 beats) → COMMIT.
  - ACT (3 beats) → COMMIT.
  - COMMIT: asserts the matching `_en` strobe for one cycle, then → IDLE.
  - DROP: accepts and discards words until a beat with `ctrl_last`, then → IDLE.
- Framing errors (each increments `cfg_err_cnt` once; no write is issued):
  - Early `ctrl_last` on a non-final expected beat → IDLE.
  - Missing `ctrl_last` on the final expected beat → DROP.
- A 4-bit beat counter tracks position within the message and resets on every header.
- `cfg_err_cnt` saturates at 0xFFFF.
- Address and data registers hold their last written value between strobes.

## Timing
- Reset values:
  - All outputs are 0, except `ctrl_ready`, which is 0 during reset and 1 in the first cycle after reset deassertion.
  - State is IDLE; `cfg_err_cnt` is 0.
- `ctrl_ready` = 1 in every state except COMMIT, where it is 0 for exactly one cycle.
- Strobe latency:
  - The strobe asserts in the cycle after the final beat is accepted.
  - Data and address outputs are stable in that same cycle and remain unchanged until the next commit.
- Throughput:
  - CAM message: 10 cycles.
  - Action message: 5 cycles.
  - Back-to-back messages are allowed; a header may be presented in the cycle after COMMIT.
- `ctrl_valid` low stalls the message in any state without losing position.
- `lookup_din_en` and `action_en` are never asserted in the same cycle.
- Reset asserted mid-message:
  - The partial message is discarded and no strobe is issued.
  - The next accepted word is treated as a header.

## Structure
- Shared package `lookup_cfg_pkg`:
  - opcode constants `OP_CAM_WR` and `OP_ACT_WR`
  - beat counts `CAM_BEATS = 9` and `ACT_BEATS = 4`
  - header field offsets
  - state encoding
- Single module with no sub-module. Word assembly is done with an indexed part-select write driven by the beat counter.

## Test plan
- CAM write: header 0x01, addr 5, stage 0; key beats 0xA0..0xA3, mask beats 0xB0..0xB3 with last on beat 8 → one `lookup_din_en` pulse 1 cycle later. Expected `lookup_din_addr` = 5, `lookup_din[255:0]` = 0xA0, `lookup_din_mask[1023:768]` = 0xB3, `ctrl_ready` = 0 for that cycle only.
- Action write: addr 0xF; data beats all-ones with last on beat 3 → `action_en` pulse with `action_addr` = 0xF and `action_data_in` = 625 ones.
- Stage mismatch (header stage 3, `STAGE` = 0, 9 beats) → no strobe, `cfg_err_cnt` stays 0.
- Framing errors:
  - Action message with `ctrl_last` on beat 2 → no strobe, `cfg_err_cnt` = 1.
  - CAM message without last on beat 8, last on beat 10 → no strobe, `cfg_err_cnt` = 2, next message processes normally.
- Random `ctrl_valid` gaps during a CAM write, then `rst` pulsed after beat 4 → no strobe. The following full action message commits correctly.
